dep_scoreboard_fwd: RTL
=======================

Name: dep_scoreboard_fwd

Overview:
- Parametrised decode-stage dependency unit; the successor to the fixed two-source, three-stage (es/ms/ws) forwarding and load-use block logic.
- Handles NSRC read operands against NFWD in-order forwarding stages.
- Adds a per-register pending-write scoreboard for long-latency writers (cache-miss loads, multi-cycle div/mult writing GPRs) that may retire out of pipeline order.
- Exports a saturating stall-cycle performance counter.
- Sits between the register file read ports and the decode-stage operand mux; drives ds_ready_go.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width (clog2 NREG).
- DW, 32, data width.
- NSRC, 2, read operands per instruction.
- NFWD, 3, forwarding stages; index 0 is the youngest stage and has the highest priority.
- MAXPEND, 3, maximum outstanding long writes per register.
- CW, 32, stall counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ds_valid  in  1  decode holds a valid instruction
- src_used  in  NSRC  operand i is actually read
- src_addr  in  NSRC*AW  operand i register number
- rf_rdata  in  NSRC*DW  register file read data for operand i
- fwd_valid  in  NFWD  stage k holds a valid GPR writer
- fwd_dest  in  NFWD*AW  stage k destination
- fwd_ok  in  NFWD  stage k result is available this cycle (0 = load still pending)
- fwd_data  in  NFWD*DW  stage k result
- issue_fire  in  1  decode instruction handed to execute this cycle
- issue_we  in  1  issuing instruction writes a GPR
- issue_long  in  1  issuing write is long-latency
- issue_dest  in  AW  issuing destination
- lwb_valid  in  1  long write retiring this cycle
- lwb_dest  in  AW  retiring destination
- flush  in  1  kill all in-flight long writes
- src_value  out  NSRC*DW  resolved operand values
- stall  out  1  decode must not issue
- stall_cnt  out  CW  cycles with ds_valid && stall

Behaviour:
- Reset (resetn=0, asynchronous): all scoreboard counters = 0, stall_cnt = 0. Combinational outputs follow their inputs.
- Match rule: operand i matches stage k iff src_used[i] && fwd_valid[k] && src_addr[i]==fwd_dest[k] && src_addr[i]!=0. Register 0 never matches, never stalls, and is never scoreboarded.
- Forward select: take the lowest k that matches.
  - If fwd_ok[k]=1: src_value[i] = fwd_data[k].
  - If fwd_ok[k]=0: operand i is "not ready". Older stages are never consulted past a not-ready match.
  - No match: src_value[i] = rf_rdata[i].
- Scoreboard: one counter per register, width clog2(MAXPEND+1).
  - pend_eff(r) = cnt[r] - (lwb_valid && lwb_dest==r).
  - An operand with no stage match and pend_eff(src_addr)>0 is "not ready".
  - A stage match overrides the scoreboard, because the youngest writer wins.
- stall = ds_valid && (any operand not ready || (issue_we && issue_long && issue_dest!=0 && pend_eff(issue_dest)==MAXPEND)). Purely combinational, zero latency.
- Counter update at posedge clk:
  - +1 on issue_fire && issue_we && issue_long && issue_dest!=0.
  - -1 on lwb_valid for lwb_dest.
  - Both on the same register in the same cycle: net unchanged.
  - Decrement at 0 is ignored and flagged by the simulation assertion.
  - Increment at MAXPEND cannot occur because issue is stalled; an assertion checks this.
- flush: at the next edge all counters = 0. This has priority over same-cycle issue and lwb. flush does not gate stall in its own cycle.
- issue_fire while stall=1 is illegal (assertion).
- stall_cnt: increments when ds_valid && stall and saturates at all-ones. It is not cleared by flush.
- Updates become visible one cycle after the causing event; the lwb same-cycle bypass is the only exception.

Decomposition:
- mycpu.h gains:
  - DEP_FWD_BUS_WD = NFWD*(1+1+AW+DW), with per-stage ordering {valid, ok, dest, data} packed, stage 0 in the LSBs.
  - LWB_BUS_WD = 1+AW, ordering {valid, dest}.
- Sub-module fwd_prio_sel: one operand's priority match and mux over NFWD stages. Outputs value and not_ready; instantiated NSRC times via generate.
- The scoreboard array and stall counter stay in the top module.

Test Plan:
- Priority and r0 handling:
  - Stages 0 and 1 both write r5 (0x11, 0x22, both ok) while src0=r5 -> src_value0=0x11, stall=0.
  - src0=r0 while stage 0 writes r0 -> value is rf_rdata, no stall.
- Load-use:
  - Stage 0 dest r8 with fwd_ok=0, src1=r8 -> stall=1 and stall_cnt increments.
  - Next cycle fwd_ok=1 with data 0xDEAD -> src_value1=0xDEAD, stall=0.
- Scoreboard basic:
  - Issue a long write to r3, no stage match, then read r3 -> stall held.
  - lwb r3 in the read cycle -> stall drops in that same cycle (pend_eff=0).
  - The counter reads 0 after the edge.
- Saturation:
  - Issue MAXPEND=3 long writes to r9, then a fourth long writer to r9 -> stall=1.
  - lwb r9 in the same cycle -> stall=0, issue allowed, counter stays 3.
- Flush and reset:
  - Pending r4=2 and r7=1, assert flush together with a lwb r4 -> all counters 0 next cycle, no stall on r4 or r7.
  - Drop resetn mid-run -> stall_cnt=0 immediately, without waiting for a clock edge.
- Counter saturation:
  - Run with CW=4 and hold stall for 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/dep_scoreboard_fwd_pkg.sv
// Shared parameters and bus-width helpers for the decode dependency unit.
// Default sizes match the reference core: 32 GPRs, 2 read operands, and
// 3 forwarding stages. Long-latency writers are tracked per register.
package dep_scoreboard_fwd_pkg;

  localparam int NREG_DEF    = 32;
  localparam int AW_DEF      = 5;
  localparam int DW_DEF      = 32;
  localparam int NSRC_DEF    = 2;
  localparam int NFWD_DEF    = 3;
  localparam int MAXPEND_DEF = 3;
  localparam int CW_DEF      = 32;

  // Packed forwarding bus width: per stage {valid, ok, dest, data}, stage 0 in the LSBs.
  function automatic int dep_fwd_bus_wd(input int nfwd, input int aw, input int dw);
    return nfwd * (1 + 1 + aw + dw);
  endfunction

  localparam int DEP_FWD_BUS_WD = NFWD_DEF * (1 + 1 + AW_DEF + DW_DEF);
  // Long-write retire bus: {valid, dest}.
  localparam int LWB_BUS_WD     = 1 + AW_DEF;

endpackage

// File: rtl/dep_scoreboard_fwd_if.sv
// Decode-stage dependency bus.
// slave  : the dependency unit. It receives the operand, forwarding, issue,
//          and retire signals, and drives src_value, stall, and stall_cnt.
// master : the surrounding pipeline, or a testbench.
interface dep_scoreboard_fwd_if
  import dep_scoreboard_fwd_pkg::*;
  #(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int NSRC = NSRC_DEF,
    parameter int NFWD = NFWD_DEF,
    parameter int CW   = CW_DEF
  );

  logic                 ds_valid;
  logic [NSRC-1:0]      src_used;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC*DW-1:0]   rf_rdata;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*AW-1:0]   fwd_dest;
  logic [NFWD-1:0]      fwd_ok;
  logic [NFWD*DW-1:0]   fwd_data;
  logic                 issue_fire;
  logic                 issue_we;
  logic                 issue_long;
  logic [AW-1:0]        issue_dest;
  logic                 lwb_valid;
  logic [AW-1:0]        lwb_dest;
  logic                 flush;
  logic [NSRC*DW-1:0]   src_value;
  logic                 stall;
  logic [CW-1:0]        stall_cnt;

  modport slave (
    input  ds_valid, src_used, src_addr, rf_rdata,
    input  fwd_valid, fwd_dest, fwd_ok, fwd_data,
    input  issue_fire, issue_we, issue_long, issue_dest,
    input  lwb_valid, lwb_dest, flush,
    output src_value, stall, stall_cnt
  );

  modport master (
    output ds_valid, src_used, src_addr, rf_rdata,
    output fwd_valid, fwd_dest, fwd_ok, fwd_data,
    output issue_fire, issue_we, issue_long, issue_dest,
    output lwb_valid, lwb_dest, flush,
    input  src_value, stall, stall_cnt
  );

endinterface

// File: rtl/dep_scoreboard_fwd_fwd_prio_sel.sv
// fwd_prio_sel: priority forwarding mux for a single read operand.
// Ports:
//   i_used, i_addr, i_rf_data      operand request and register-file data
//   i_fwd_valid/dest/ok/data       per-stage forwarding sources (stage 0 = youngest)
//   o_value                        selected value (forwarded data, or register-file data)
//   o_match                        some stage matched (the scoreboard is then bypassed)
//   o_not_ready                    the highest-priority match has no result yet
module fwd_prio_sel
  import dep_scoreboard_fwd_pkg::*;
  #(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int NFWD = NFWD_DEF
  ) (
    input  logic              i_used,
    input  logic [AW-1:0]     i_addr,
    input  logic [DW-1:0]     i_rf_data,
    input  logic [NFWD-1:0]   i_fwd_valid,
    input  logic [NFWD*AW-1:0] i_fwd_dest,
    input  logic [NFWD-1:0]   i_fwd_ok,
    input  logic [NFWD*DW-1:0] i_fwd_data,
    output logic [DW-1:0]     o_value,
    output logic              o_match,
    output logic              o_not_ready
  );

  // Walk from the oldest stage to the youngest. Each later hit overwrites the
  // previous one, so the lowest matching index wins. A pending younger match
  // therefore hides any ready result in an older stage.
  always_comb begin
    o_value     = i_rf_data;
    o_match     = 1'b0;
    o_not_ready = 1'b0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (i_used && (i_addr != '0) && i_fwd_valid[k] &&
          (i_fwd_dest[k*AW +: AW] == i_addr)) begin
        o_match     = 1'b1;
        o_not_ready = !i_fwd_ok[k];
        o_value     = i_fwd_data[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/dep_scoreboard_fwd.sv
// dep_scoreboard_fwd: decode-stage operand forwarding and hazard stall unit.
// It resolves NSRC operands against NFWD in-order forwarding stages, and keeps
// a per-register pending-write count for long-latency writers that can retire
// out of pipeline order.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   bus          dep_scoreboard_fwd_if.slave. It carries the operand and
//                forwarding inputs, the issue, retire, and flush events, and
//                the src_value, stall, and stall_cnt outputs.
module dep_scoreboard_fwd
  import dep_scoreboard_fwd_pkg::*;
  #(
    parameter int NREG    = NREG_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int NSRC    = NSRC_DEF,
    parameter int NFWD    = NFWD_DEF,
    parameter int MAXPEND = MAXPEND_DEF,
    parameter int CW      = CW_DEF
  ) (
    input  logic clk,
    input  logic resetn,
    dep_scoreboard_fwd_if.slave bus
  );

  localparam int PW = $clog2(MAXPEND + 1);

  logic [PW-1:0]      r_pend [NREG];
  logic [CW-1:0]      r_stall_cnt;

  logic [PW-1:0]      w_pend_eff [NREG];
  logic [NREG-1:0]    w_inc;
  logic [NREG-1:0]    w_dec;
  logic [NSRC-1:0]    w_match;
  logic [NSRC-1:0]    w_fwd_nr;
  logic [NSRC-1:0]    w_not_ready;
  logic [NSRC*DW-1:0] w_value;
  logic               w_issue_long;
  logic               w_full;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    fwd_prio_sel #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_sel (
      .i_used      (bus.src_used[g]),
      .i_addr      (bus.src_addr[g*AW +: AW]),
      .i_rf_data   (bus.rf_rdata[g*DW +: DW]),
      .i_fwd_valid (bus.fwd_valid),
      .i_fwd_dest  (bus.fwd_dest),
      .i_fwd_ok    (bus.fwd_ok),
      .i_fwd_data  (bus.fwd_data),
      .o_value     (w_value[g*DW +: DW]),
      .o_match     (w_match[g]),
      .o_not_ready (w_fwd_nr[g])
    );
  end

  assign w_issue_long = bus.issue_we && bus.issue_long && (bus.issue_dest != '0);

  // A retire in the current cycle releases its register immediately.
  // A retire aimed at a zero count is ignored here, so the value cannot wrap.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_dec[r] = bus.lwb_valid && (bus.lwb_dest == AW'(r)) && (r_pend[r] != '0);
      w_inc[r] = bus.issue_fire && w_issue_long && (bus.issue_dest == AW'(r));
      w_pend_eff[r] = r_pend[r] - (w_dec[r] ? PW'(1) : PW'(0));
    end
  end

  // A forwarding match takes precedence over the scoreboard, because the youngest writer wins.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      if (w_match[i]) begin
        w_not_ready[i] = w_fwd_nr[i];
      end else begin
        w_not_ready[i] = bus.src_used[i] && (bus.src_addr[i*AW +: AW] != '0) &&
                         (w_pend_eff[bus.src_addr[i*AW +: AW]] != '0);
      end
    end
  end

  assign w_full        = w_issue_long && (w_pend_eff[bus.issue_dest] == PW'(MAXPEND));
  assign bus.stall     = bus.ds_valid && ((|w_not_ready) || w_full);
  assign bus.src_value = w_value;
  assign bus.stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) r_pend[r] <= '0;
    end else if (bus.flush) begin
      for (int r = 0; r < NREG; r++) r_pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          r_pend[r] <= r_pend[r] + PW'(1);
        end else if (w_dec[r] && !w_inc[r]) begin
          r_pend[r] <= r_pend[r] - PW'(1);
        end
      end
    end
  end

  // Flush does not clear this counter; it tracks stall cycles across pipeline kills.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (bus.stall && (r_stall_cnt != {CW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  // Protocol checks. A synthesis flow ignores these.
  always @(posedge clk) begin
    if (resetn) begin
      a_issue_while_stall: assert (!(bus.issue_fire && bus.stall));
      a_lwb_underflow: assert (bus.flush || !bus.lwb_valid || (bus.lwb_dest == '0) ||
                               (r_pend[bus.lwb_dest] != '0));
      a_pend_overflow: assert (bus.flush || !(bus.issue_fire && w_issue_long &&
                               (w_pend_eff[bus.issue_dest] == PW'(MAXPEND))));
    end
  end

endmodule
